pipelined_multiplier: RTL and testbench
=======================================

Name: pipelined_multiplier

Overview:
Parametrised, fully pipelined WIDTH x WIDTH integer multiplier with selectable result mode: low half, unsigned high half, signed high half, or multiply-accumulate. It is the general successor of the fixed 16-bit, 2-cycle DSP multiplier. It serves as the core's multiply functional unit, with a valid tag carried alongside the data. The multiply is written behaviourally so synthesis can map it onto DSP slices; it issues one operation per cycle and never stalls.

Parameters:
WIDTH, 16, operand and result width in bits (2..32)
LATENCY, 2, cycles from valid_in to valid_out (1..4); the extra stages are input/product retiming registers

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in0  input  WIDTH  operand A
in1  input  WIDTH  operand B
op  input  2  00 MUL_LO, 01 MULH_U, 10 MULH_S, 11 MAC
acc_clear  input  1  with op=MAC: start a new accumulation (treat acc as 0)
valid_in  input  1  operands, op and acc_clear are valid this cycle
out  output  WIDTH  result
valid_out  output  1  out is valid this cycle

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. The ports are named clock and reset.
- Reset values: every valid stage 0, valid_out 0, out 0, accumulator 0. Reset applied mid-operation drops all in-flight operations; no valid_out follows for them.
- Pipeline: op, acc_clear and valid travel through LATENCY stages with the data. An operation accepted at cycle t appears at cycle t+LATENCY. Throughput is 1 operation per cycle, with no backpressure.
- Product widths: P_u = unsigned 2*WIDTH-bit product; P_s = signed 2*WIDTH-bit product of the sign-extended operands.
- MUL_LO: out = P_u[WIDTH-1:0]. Signed and unsigned give the same result.
- MULH_U: out = P_u[2*WIDTH-1:WIDTH].
- MULH_S: out = P_s[2*WIDTH-1:WIDTH].
- MAC: acc_next = (acc_clear ? 0 : acc) + P_u[WIDTH-1:0], taken modulo 2^WIDTH. Both out and acc get acc_next in the final stage.
  - Back-to-back MACs must chain: the accumulator add sits in the final stage, so the feedback path is a single cycle.
- Accumulator update rules: acc updates only on a final-stage valid MAC. Non-MAC ops and bubbles (valid=0) leave acc unchanged, and a non-MAC op never disturbs a MAC sequence.
- acc_clear is ignored when op != MAC.
- out holds its last value whenever valid_out=0.
- Boundary rules:
  - WIDTH=2 must work.
  - LATENCY=1 means only the output register exists.
  - A valid_in arriving in the same cycle that reset is high is discarded.

Optional Feature:
Macro PIPELINED_MULTIPLIER_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), registered, reset 0, aligned with valid_out.
  - MUL_LO: overflow = (P_u[2*WIDTH-1:WIDTH] != 0).
  - MAC: overflow = carry-out of the accumulator add, or the MUL_LO condition on the product.
  - MULH_U / MULH_S: overflow = 0.
  - overflow = 0 when valid_out=0.
- Not defined: the port does not exist and no logic is generated. All other behaviour is identical.

Test Plan:
All scenarios use WIDTH=16, LATENCY=2 unless stated.
1. MUL_LO 0x0003*0x0005 at cycle 0 -> valid_out=1 and out=0x000F at cycle 2 only.
2. 0xFFFF*0xFFFF in three consecutive cycles as MUL_LO, MULH_U, MULH_S -> out 0x0001, 0xFFFE, 0x0000 on three consecutive cycles; with the macro, overflow 1, 0, 0.
3. Back-to-back MAC: (2,3,clear=1), (4,5,clear=0), bubble, MUL_LO (7,7), MAC (1,1,clear=0) -> out 6, 26, no valid, 49, 27.
4. MAC wrap: (0xFFFF,1,clear=1) then (1,1,clear=0) -> out 0xFFFF then 0x0000; with the macro, overflow 0 then 1.
5. Reset mid-flight: valid MUL_LO at cycle 0, reset=1 at cycle 1 -> valid_out stays 0 through cycle 4, out=0, and a subsequent MAC with clear=0, (2,2) -> 4.
6. Repeat scenarios 1 and 3 with LATENCY=1 and LATENCY=4 -> same values, shifted to latency 1 and 4 respectively.

Source files
------------

// File: rtl/pipelined_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_multiplier
//
// Fully pipelined WIDTH x WIDTH integer multiplier for the core's multiply
// functional unit. It accepts one operation per cycle, never stalls, and
// returns each result LATENCY cycles after it was accepted.
//
// Result modes (op):
//   00 MUL_LO  low half of the product (sign-agnostic)
//   01 MULH_U  high half of the unsigned product
//   10 MULH_S  high half of the signed product
//   11 MAC     acc = (acc_clear ? 0 : acc) + low half of product
//
// Parameters:
//   WIDTH    operand/result width, 2..32
//   LATENCY  cycles from valid_in to valid_out, 1..4. LATENCY-1 input
//            retiming stages sit in front of the output/accumulator stage.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in0, in1   operands A and B
//   op         result mode
//   acc_clear  MAC only: start a fresh accumulation
//   valid_in   operands, op and acc_clear are valid this cycle
//   out        result; holds its last value while valid_out is low
//   overflow   (optional) registered overflow flag aligned with valid_out
//   valid_out  out is valid this cycle
//
// Optional feature: define PIPELINED_MULTIPLIER_OVERFLOW_EN to add the
// overflow output. Without it the port and its logic do not exist.
// ---------------------------------------------------------------------------
module pipelined_multiplier #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [1:0]       op,
  input  logic             acc_clear,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out,
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             valid_out
);

  localparam int N_PRE = LATENCY - 1;

  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MULH_U = 2'b01,
    OP_MULH_S = 2'b10,
    OP_MAC    = 2'b11
  } op_e;

  // Everything that travels with an operation down the pipe.
  typedef struct packed {
    logic             valid;
    op_e              op;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t w_in;
  stage_t w_fin;

  always_comb begin
    w_in.valid = valid_in;
    w_in.op    = op_e'(op);
    w_in.clr   = acc_clear;
    w_in.a     = in0;
    w_in.b     = in1;
  end

  // -------------------------------------------------------------------------
  // Input retiming stages (absent when LATENCY == 1)
  // -------------------------------------------------------------------------
  generate
    if (N_PRE == 0) begin : g_no_pre
      assign w_fin = w_in;
    end else begin : g_pre
      stage_t r_pipe [N_PRE];

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the previous stage's old value on the same edge.
      always_ff @(posedge clock) begin
        r_pipe[0] <= w_in;
        for (int i = 1; i < N_PRE; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
        // NOTE: only the valid bits are reset; the data fields are qualified
        // by valid, so clearing them would just add reset fan-out to the
        // datapath and block DSP register absorption.
        if (reset) begin
          for (int i = 0; i < N_PRE; i++) begin
            r_pipe[i].valid <= 1'b0;
          end
        end
      end

      assign w_fin = r_pipe[N_PRE-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Final stage: product, accumulator add, result select
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]   r_out;
  logic               r_valid;
  logic [WIDTH-1:0]   r_acc;

  logic               w_signed;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_acc_base;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_result;

  // One multiplier serves every mode: operands are sign- or zero-extended to
  // 2*WIDTH, so the truncated product equals P_s for MULH_S and P_u otherwise.
  // The low half is identical in both cases.
  always_comb begin
    w_signed   = (w_fin.op == OP_MULH_S);
    w_a_ext    = {{WIDTH{w_signed & w_fin.a[WIDTH-1]}}, w_fin.a};
    w_b_ext    = {{WIDTH{w_signed & w_fin.b[WIDTH-1]}}, w_fin.b};
    w_prod     = w_a_ext * w_b_ext;
    w_acc_base = w_fin.clr ? '0 : r_acc;
  end

`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
  logic w_carry;
  assign {w_carry, w_acc_next} = {1'b0, w_acc_base} + {1'b0, w_prod[WIDTH-1:0]};
`else
  assign w_acc_next = w_acc_base + w_prod[WIDTH-1:0];
`endif

  // NOTE: the default is assigned before the case so no path leaves
  // w_result unassigned, which would otherwise infer a latch.
  always_comb begin
    w_result = w_prod[WIDTH-1:0];
    case (w_fin.op)
      OP_MULH_U,
      OP_MULH_S: w_result = w_prod[2*WIDTH-1:WIDTH];
      OP_MAC:    w_result = w_acc_next;
      default:   w_result = w_prod[WIDTH-1:0];
    endcase
  end

  // The accumulator add lives in this stage so back-to-back MACs see the
  // previous result after a single cycle of feedback.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_valid <= w_fin.valid;
      if (w_fin.valid) begin
        r_out <= w_result;
        if (w_fin.op == OP_MAC) begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

  assign out       = r_out;
  assign valid_out = r_valid;

`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
  logic r_overflow;
  logic w_overflow;

  always_comb begin
    w_overflow = 1'b0;
    case (w_fin.op)
      OP_MUL_LO: w_overflow = |w_prod[2*WIDTH-1:WIDTH];
      OP_MAC:    w_overflow = w_carry | (|w_prod[2*WIDTH-1:WIDTH]);
      default:   w_overflow = 1'b0;
    endcase
  end

  // Cleared on bubbles so the flag is only ever high alongside valid_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_fin.valid & w_overflow;
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
// ---------------------------------------------------------------------------
// tb_pipelined_multiplier
//
// Drives three instances (LATENCY 1, 2 and 4, WIDTH 16) from shared inputs
// and compares each against hand-computed expected values, shifted by that
// instance's latency. Inputs change just after the falling edge; outputs are
// sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_pipelined_multiplier;

  localparam int W     = 16;
  localparam int DEPTH = 32;

  localparam logic [1:0] OP_LO  = 2'b00;
  localparam logic [1:0] OP_HU  = 2'b01;
  localparam logic [1:0] OP_HS  = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [1:0]   op;
  logic         acc_clear;
  logic         valid_in;

  logic [W-1:0] out_l1, out_l2, out_l4;
  logic         vld_l1, vld_l2, vld_l4;
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
  logic         ovf_l1, ovf_l2, ovf_l4;
`endif

  always #5 clock = ~clock;

  pipelined_multiplier #(.WIDTH(W), .LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(reset), .in0(in0), .in1(in1), .op(op),
    .acc_clear(acc_clear), .valid_in(valid_in), .out(out_l1),
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
    .overflow(ovf_l1),
`endif
    .valid_out(vld_l1)
  );

  pipelined_multiplier #(.WIDTH(W), .LATENCY(2)) u_dut_l2 (
    .clock(clock), .reset(reset), .in0(in0), .in1(in1), .op(op),
    .acc_clear(acc_clear), .valid_in(valid_in), .out(out_l2),
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
    .overflow(ovf_l2),
`endif
    .valid_out(vld_l2)
  );

  pipelined_multiplier #(.WIDTH(W), .LATENCY(4)) u_dut_l4 (
    .clock(clock), .reset(reset), .in0(in0), .in1(in1), .op(op),
    .acc_clear(acc_clear), .valid_in(valid_in), .out(out_l4),
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
    .overflow(ovf_l4),
`endif
    .valid_out(vld_l4)
  );

  int n_checks = 0;
  int n_errors = 0;
  int lat [3] = '{1, 2, 4};

  typedef struct {
    logic         v;
    logic [1:0]   op;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  logic         smp_v [3][DEPTH];
  logic [W-1:0] smp_o [3][DEPTH];
  logic         smp_f [3][DEPTH];

  task automatic add_vec(input logic v, input logic [1:0] o, input logic c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input logic f);
    vecs.push_back(vec_t'{v, o, c, a, b, e, f});
  endtask

  task automatic drive_idle();
    valid_in  = 1'b0;
    op        = OP_LO;
    acc_clear = 1'b0;
    in0       = '0;
    in1       = '0;
  endtask

  task automatic sample(input int c);
    smp_v[0][c] = vld_l1; smp_o[0][c] = out_l1;
    smp_v[1][c] = vld_l2; smp_o[1][c] = out_l2;
    smp_v[2][c] = vld_l4; smp_o[2][c] = out_l4;
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
    smp_f[0][c] = ovf_l1; smp_f[1][c] = ovf_l2; smp_f[2][c] = ovf_l4;
`else
    for (int k = 0; k < 3; k++) smp_f[k][c] = 1'b0;
`endif
  endtask

  // Applies vecs one per cycle starting at cycle 0, then idles long enough
  // to flush the deepest pipe. The sample for cycle c lands in slot c.
  task automatic drive_vectors();
    for (int c = 0; c < vecs.size() + 6; c++) begin
      if (c < vecs.size()) begin
        valid_in  = vecs[c].v;
        op        = vecs[c].op;
        acc_clear = vecs[c].clr;
        in0       = vecs[c].a;
        in1       = vecs[c].b;
      end else begin
        drive_idle();
      end
      @(posedge clock);
      @(negedge clock);
      sample(c + 1);
    end
    drive_idle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    sample(0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (smp_v[k][0] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_valid L=%0d: got %b expected 0", lat[k], smp_v[k][0]);
      end
      n_checks++;
      if (smp_o[k][0] !== '0) begin
        n_errors++;
        $display("FAIL reset_out L=%0d: got %h expected 0000", lat[k], smp_o[k][0]);
      end
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
      n_checks++;
      if (smp_f[k][0] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_ovf L=%0d: got %b expected 0", lat[k], smp_f[k][0]);
      end
`endif
    end
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_mul_lo();
    vecs.delete();
    add_vec(1'b1, OP_LO, 1'b0, 16'h0003, 16'h0005, 16'h000F, 1'b0);
    add_vec(1'b1, OP_LO, 1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1);
    drive_vectors();
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= vecs.size() + 6; c++) begin
        int   idx;
        logic ev;
        idx = c - lat[k];
        ev  = (idx >= 0 && idx < vecs.size()) ? vecs[idx].v : 1'b0;
        n_checks++;
        if (smp_v[k][c] !== ev) begin
          n_errors++;
          $display("FAIL mul_lo_valid L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_v[k][c], ev);
        end
        if (ev) begin
          n_checks++;
          if (smp_o[k][c] !== vecs[idx].exp) begin
            n_errors++;
            $display("FAIL mul_lo_out L=%0d cycle %0d: got %h expected %h", lat[k], c, smp_o[k][c], vecs[idx].exp);
          end
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
          n_checks++;
          if (smp_f[k][c] !== vecs[idx].ovf) begin
            n_errors++;
            $display("FAIL mul_lo_ovf L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_f[k][c], vecs[idx].ovf);
          end
`endif
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_high_halves();
    vecs.delete();
    // 0xFFFF*0xFFFF = 0xFFFE0001 unsigned; (-1)*(-1) = 1 signed
    add_vec(1'b1, OP_LO, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    add_vec(1'b1, OP_HU, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    add_vec(1'b1, OP_HS, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    // 0x8000*2: unsigned 0x00010000, signed -65536 = 0xFFFF0000
    add_vec(1'b1, OP_HU, 1'b0, 16'h8000, 16'h0002, 16'h0001, 1'b0);
    add_vec(1'b1, OP_HS, 1'b0, 16'h8000, 16'h0002, 16'hFFFF, 1'b0);
    drive_vectors();
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= vecs.size() + 6; c++) begin
        int   idx;
        logic ev;
        idx = c - lat[k];
        ev  = (idx >= 0 && idx < vecs.size()) ? vecs[idx].v : 1'b0;
        n_checks++;
        if (smp_v[k][c] !== ev) begin
          n_errors++;
          $display("FAIL high_valid L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_v[k][c], ev);
        end
        if (ev) begin
          n_checks++;
          if (smp_o[k][c] !== vecs[idx].exp) begin
            n_errors++;
            $display("FAIL high_out L=%0d cycle %0d: got %h expected %h", lat[k], c, smp_o[k][c], vecs[idx].exp);
          end
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
          n_checks++;
          if (smp_f[k][c] !== vecs[idx].ovf) begin
            n_errors++;
            $display("FAIL high_ovf L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_f[k][c], vecs[idx].ovf);
          end
`endif
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_mac_wrap();
    vecs.delete();
    add_vec(1'b1, OP_MAC, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
    add_vec(1'b1, OP_MAC, 1'b0, 16'h0001, 16'h0001, 16'h0000, 1'b1);
    drive_vectors();
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= vecs.size() + 6; c++) begin
        int   idx;
        logic ev;
        idx = c - lat[k];
        ev  = (idx >= 0 && idx < vecs.size()) ? vecs[idx].v : 1'b0;
        n_checks++;
        if (smp_v[k][c] !== ev) begin
          n_errors++;
          $display("FAIL wrap_valid L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_v[k][c], ev);
        end
        if (ev) begin
          n_checks++;
          if (smp_o[k][c] !== vecs[idx].exp) begin
            n_errors++;
            $display("FAIL wrap_out L=%0d cycle %0d: got %h expected %h", lat[k], c, smp_o[k][c], vecs[idx].exp);
          end
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
          n_checks++;
          if (smp_f[k][c] !== vecs[idx].ovf) begin
            n_errors++;
            $display("FAIL wrap_ovf L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_f[k][c], vecs[idx].ovf);
          end
`endif
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Back-to-back MACs, a bubble, and a MUL_LO (with acc_clear set, which must
  // be ignored) in the middle of the accumulation. Also checks that out holds
  // through the bubble.
  task automatic test_back_to_back();
    vecs.delete();
    add_vec(1'b1, OP_MAC, 1'b1, 16'd2, 16'd3, 16'd6,  1'b0);
    add_vec(1'b1, OP_MAC, 1'b0, 16'd4, 16'd5, 16'd26, 1'b0);
    add_vec(1'b0, OP_MAC, 1'b1, 16'd9, 16'd9, 16'd0,  1'b0);
    add_vec(1'b1, OP_LO,  1'b1, 16'd7, 16'd7, 16'd49, 1'b0);
    add_vec(1'b1, OP_MAC, 1'b0, 16'd1, 16'd1, 16'd27, 1'b0);
    drive_vectors();
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] held;
      logic         have_held;
      have_held = 1'b0;
      held      = '0;
      for (int c = 1; c <= vecs.size() + 6; c++) begin
        int   idx;
        logic ev;
        idx = c - lat[k];
        ev  = (idx >= 0 && idx < vecs.size()) ? vecs[idx].v : 1'b0;
        n_checks++;
        if (smp_v[k][c] !== ev) begin
          n_errors++;
          $display("FAIL b2b_valid L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_v[k][c], ev);
        end
        if (ev) begin
          n_checks++;
          if (smp_o[k][c] !== vecs[idx].exp) begin
            n_errors++;
            $display("FAIL b2b_out L=%0d cycle %0d: got %h expected %h", lat[k], c, smp_o[k][c], vecs[idx].exp);
          end
          held      = vecs[idx].exp;
          have_held = 1'b1;
        end else if (have_held) begin
          n_checks++;
          if (smp_o[k][c] !== held) begin
            n_errors++;
            $display("FAIL b2b_hold L=%0d cycle %0d: got %h expected %h", lat[k], c, smp_o[k][c], held);
          end
        end
`ifdef PIPELINED_MULTIPLIER_OVERFLOW_EN
        n_checks++;
        if (smp_f[k][c] !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_ovf L=%0d cycle %0d: got %b expected 0", lat[k], c, smp_f[k][c]);
        end
`endif
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // MUL_LO 3*5 at cycle 0, reset at cycle 1 together with a valid 9*9 that
  // must be discarded. LATENCY=1 delivers 3*5 at cycle 1, before the reset
  // edge; the deeper pipes must drop it. The accumulator (27 from the
  // previous test) must be back at 0 afterwards.
  task automatic test_reset_mid_flight();
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      reset = 1'b0;
      if (c == 0) begin
        valid_in = 1'b1; op = OP_LO; in0 = 16'd3; in1 = 16'd5;
      end else if (c == 1) begin
        reset = 1'b1;
        valid_in = 1'b1; op = OP_LO; in0 = 16'd9; in1 = 16'd9;
      end
      @(posedge clock);
      @(negedge clock);
      sample(c + 1);
    end
    reset = 1'b0;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= 4; c++) begin
        logic ev;
        ev = (k == 0 && c == 1);
        n_checks++;
        if (smp_v[k][c] !== ev) begin
          n_errors++;
          $display("FAIL rst_flight_valid L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_v[k][c], ev);
        end
        if (ev) begin
          n_checks++;
          if (smp_o[k][c] !== 16'h000F) begin
            n_errors++;
            $display("FAIL rst_flight_out L=%0d cycle %0d: got %h expected 000f", lat[k], c, smp_o[k][c]);
          end
        end else if (c >= 2) begin
          n_checks++;
          if (smp_o[k][c] !== '0) begin
            n_errors++;
            $display("FAIL rst_flight_out L=%0d cycle %0d: got %h expected 0000", lat[k], c, smp_o[k][c]);
          end
        end
      end
    end

    vecs.delete();
    add_vec(1'b1, OP_MAC, 1'b0, 16'd2, 16'd2, 16'd4, 1'b0);
    drive_vectors();
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= vecs.size() + 6; c++) begin
        int   idx;
        logic ev;
        idx = c - lat[k];
        ev  = (idx >= 0 && idx < vecs.size()) ? vecs[idx].v : 1'b0;
        n_checks++;
        if (smp_v[k][c] !== ev) begin
          n_errors++;
          $display("FAIL post_rst_valid L=%0d cycle %0d: got %b expected %b", lat[k], c, smp_v[k][c], ev);
        end
        if (ev) begin
          n_checks++;
          if (smp_o[k][c] !== vecs[idx].exp) begin
            n_errors++;
            $display("FAIL post_rst_mac L=%0d cycle %0d: got %h expected %h", lat[k], c, smp_o[k][c], vecs[idx].exp);
          end
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    drive_idle();
    @(negedge clock);
    test_reset();
    test_mul_lo();
    test_high_halves();
    test_mac_wrap();
    test_back_to_back();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
